// File: rtl/fetch_pkg.sv
// ============================================================================
//  Module      : fetch_pkg
//  Description : Shared types and constants for the instruction fetch block:
//                controller state encoding, word geometry and PC alignment.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fetch_pkg;

  // Controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

  localparam int          INSTR_W        = 32;
  localparam int          BYTES_PER_WORD = 4;
  localparam logic [31:0] PC_ALIGN_MASK  = 32'hFFFF_FFFC;

  // Force a byte address onto a word boundary.
  function automatic logic [31:0] align_pc(input logic [31:0] addr);
    return addr & PC_ALIGN_MASK;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_if.sv
// ============================================================================
//  Module      : fetch_if
//  Description : Bundles the ROM port, redirect inputs and the decode-side
//                valid/ready handshake of the fetch controller.
//                master : the fetch controller
//                slave  : ROM + decode + redirect source (environment)
//  Ports       : start, mem_addr, mem_instr, branch_taken, branch_target,
//                out_valid, out_ready, out_instr, out_pc, halted, fetch_count
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface fetch_if #(
  parameter int COUNT_W = 16
) ();
  import fetch_pkg::*;

  logic                 start;
  logic [31:0]          mem_addr;
  logic [INSTR_W-1:0]   mem_instr;
  logic                 branch_taken;
  logic [31:0]          branch_target;
  logic                 out_valid;
  logic                 out_ready;
  logic [INSTR_W-1:0]   out_instr;
  logic [31:0]          out_pc;
  logic                 halted;
  logic [COUNT_W-1:0]   fetch_count;

  modport master (
    input  start, mem_instr, branch_taken, branch_target, out_ready,
    output mem_addr, out_valid, out_instr, out_pc, halted, fetch_count
  );

  modport slave (
    output start, mem_instr, branch_taken, branch_target, out_ready,
    input  mem_addr, out_valid, out_instr, out_pc, halted, fetch_count
  );

endinterface

`default_nettype wire

// File: rtl/fetch_out_reg.sv
// ============================================================================
//  Module      : fetch_out_reg
//  Description : Single-entry valid/ready output buffer. Priority:
//                flush > load > drain-on-handshake > hold.
//  Ports       : clk, reset         - clock, sync active-high reset
//                load_i             - capture instr_i/pc_i, set valid
//                flush_i            - drop the held entry
//                ready_i            - consumer ready (drains when valid)
//                instr_i, pc_i      - entry to capture
//                valid_o, instr_o, pc_o - held entry
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_out_reg
  import fetch_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               ready_i,
  input  logic [INSTR_W-1:0] instr_i,
  input  logic [31:0]        pc_i,
  output logic               valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [31:0]        pc_o
);

  logic               valid_q;
  logic [INSTR_W-1:0] instr_q;
  logic [31:0]        pc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      instr_q <= '0;
      pc_q    <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      instr_q <= instr_i;
      pc_q    <= pc_i;
    end else if (valid_q && ready_i) begin
      valid_q <= 1'b0;
    end
  end

  // Data is only rewritten on load, so it stays stable under backpressure.
  assign valid_o = valid_q;
  assign instr_o = instr_q;
  assign pc_o    = pc_q;

endmodule

`default_nettype wire

// File: rtl/fetch_controller.sv
// ============================================================================
//  Module      : fetch_controller
//  Description : Owns the PC, addresses the combinational instruction ROM and
//                hands each fetched word with its PC to decode over a
//                valid/ready handshake. Handles start, branch redirect with
//                flush, end-of-program halt and a saturating delivery count.
//  Ports       : clk, reset - clock, sync active-high reset
//                bus        - fetch_if.master (ROM, redirect, decode side)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_controller
  import fetch_pkg::*;
#(
  parameter int          NUM_INSTRUCTIONS = 3,
  parameter logic [31:0] RESET_PC         = 32'h0,
  parameter int          COUNT_W          = 16
) (
  input  logic     clk,
  input  logic     reset,
  fetch_if.master  bus
);

  // First byte address past the program.
  localparam logic [31:0] PC_LIMIT = 32'(BYTES_PER_WORD * NUM_INSTRUCTIONS);

  fetch_state_e       state_q;
  logic [31:0]        pc_q;
  logic [COUNT_W-1:0] count_q;

  logic               w_valid;
  logic [INSTR_W-1:0] w_instr;
  logic [31:0]        w_out_pc;
  logic [31:0]        w_target;
  logic               w_target_oor;
  logic               w_pc_oor;
  logic               w_fire;
  logic               w_load;
  logic               w_flush;

  assign w_target     = align_pc(bus.branch_target);
  assign w_target_oor = (w_target >= PC_LIMIT);
  assign w_pc_oor     = (pc_q >= PC_LIMIT);
  assign w_fire       = w_valid && bus.out_ready;

  // Output-buffer control. A redirect flushes in FETCH and HALT; a load only
  // happens in FETCH with an in-range pc and a slot that is free this cycle.
  always_comb begin
    w_load  = 1'b0;
    w_flush = 1'b0;
    if (state_q == ST_FETCH) begin
      if (bus.branch_taken)
        w_flush = 1'b1;
      else if (!w_pc_oor && (!w_valid || bus.out_ready))
        w_load = 1'b1;
    end else if (state_q == ST_HALT) begin
      w_flush = bus.branch_taken;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      count_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) state_q <= ST_FETCH;
        end
        ST_FETCH: begin
          if (bus.branch_taken) begin
            pc_q    <= w_target;
            state_q <= w_target_oor ? ST_HALT : ST_FETCH;
          end else if (w_pc_oor) begin
            state_q <= ST_HALT;
          end else if (w_load) begin
            pc_q <= pc_q + 32'(BYTES_PER_WORD);
          end
        end
        ST_HALT: begin
          // Out-of-range targets still update pc but remain halted.
          if (bus.branch_taken) begin
            pc_q    <= w_target;
            state_q <= w_target_oor ? ST_HALT : ST_FETCH;
          end
        end
        default: state_q <= ST_IDLE;
      endcase

      // Counts every handshake, including one coinciding with a flush.
      if (w_fire && (count_q != {COUNT_W{1'b1}}))
        count_q <= count_q + 1'b1;
    end
  end

  fetch_out_reg u_out_reg (
    .clk     (clk),
    .reset   (reset),
    .load_i  (w_load),
    .flush_i (w_flush),
    .ready_i (bus.out_ready),
    .instr_i (bus.mem_instr),
    .pc_i    (pc_q),
    .valid_o (w_valid),
    .instr_o (w_instr),
    .pc_o    (w_out_pc)
  );

  assign bus.mem_addr    = pc_q;
  assign bus.out_valid   = w_valid;
  assign bus.out_instr   = w_instr;
  assign bus.out_pc      = w_out_pc;
  assign bus.halted      = (state_q == ST_HALT) && !w_valid;
  assign bus.fetch_count = count_q;

endmodule

`default_nettype wire

// File: tb/tb_fetch_controller.sv
// ============================================================================
//  Module      : tb_fetch_controller
//  Description : Self-checking bench for fetch_controller. Expected deliveries
//                are queued when a run is launched and popped on handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fetch_controller;
  import fetch_pkg::*;

  localparam int COUNT_W = 16;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  fetch_if #(.COUNT_W(COUNT_W)) bus ();

  fetch_controller #(
    .NUM_INSTRUCTIONS (3),
    .RESET_PC         (32'h0),
    .COUNT_W          (COUNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  function automatic logic [31:0] rom_word(input logic [31:0] addr);
    case (addr)
      32'h0:   return 32'h0050_0093;
      32'h4:   return 32'h00A0_0113;
      32'h8:   return 32'h0020_81B3;
      default: return 32'h0;
    endcase
  endfunction

  assign bus.mem_instr = rom_word(bus.mem_addr);

  // Scoreboard consumer: every handshake must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset && bus.out_valid && bus.out_ready) begin
      n_tests++;
      if (sb_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected: got pc=%h instr=%h, expected no delivery",
                 bus.out_pc, bus.out_instr);
      end else begin
        mon_e = sb_q.pop_front();
        if (bus.out_pc !== mon_e.pc || bus.out_instr !== mon_e.instr) begin
          n_fail++;
          $display("FAIL sb_data: got pc=%h instr=%h, expected pc=%h instr=%h",
                   bus.out_pc, bus.out_instr, mon_e.pc, mon_e.instr);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_run(input logic [31:0] first_pc);
    for (logic [31:0] a = first_pc; a < 32'd12; a += 32'd4)
      sb_q.push_back('{pc: a, instr: rom_word(a)});
  endtask

  task automatic do_reset();
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.out_ready     = 1'b0;
    cyc();
    cyc();
    reset = 1'b0;
    sb_q.delete();
  endtask

  // Waits (bounded) for halt, then checks queue drained and delivery count.
  task automatic run_to_halt(input string name, input int exp_count);
    int k;
    k = 0;
    while (!bus.halted && k < 20) begin
      cyc();
      k++;
    end
    n_tests++;
    if (bus.halted !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_halt_timeout: halted=%b after %0d cycles, expected 1", name, bus.halted, k);
    end
    n_tests++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s_undelivered: %0d entries left, expected 0", name, sb_q.size());
    end
    n_tests++;
    if (bus.fetch_count !== 16'(exp_count)) begin
      n_fail++;
      $display("FAIL %s_count: got %0d, expected %0d", name, bus.fetch_count, exp_count);
    end
  endtask

  task automatic test_reset();
    do_reset();
    n_tests += 6;
    if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h, expected 0", bus.mem_addr); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL rst_instr: got %h, expected 0", bus.out_instr); end
    if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h, expected 0", bus.out_pc); end
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL rst_halted: got %b, expected 0", bus.halted); end
    if (bus.fetch_count !== 16'h0) begin n_fail++; $display("FAIL rst_count: got %0d, expected 0", bus.fetch_count); end
  endtask

  task automatic test_basic();
    logic [31:0] exp_pc;
    do_reset();
    push_run(32'h0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_latency: valid=%b one cycle after start, expected 0", bus.out_valid); end
    exp_pc = 32'h0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if ({bus.out_valid, bus.out_pc} !== {1'b1, exp_pc}) begin
        n_fail++;
        $display("FAIL basic_stream%0d: valid=%b pc=%h, expected valid=1 pc=%h", i, bus.out_valid, bus.out_pc, exp_pc);
      end
      exp_pc += 32'd4;
    end
    cyc();
    n_tests++;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL basic_halted: got %b, expected 1", bus.halted); end
    run_to_halt("basic", 3);
  endtask

  task automatic test_halt_branch();
    // Continues from the halted state left by test_basic (count 3).
    push_run(32'h0);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h0;
    cyc();
    bus.branch_taken = 1'b0;
    n_tests++;
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL hbr_leave: halted=%b after in-range branch, expected 0", bus.halted); end
    run_to_halt("hbr", 6);
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h100;
    cyc();
    bus.branch_taken = 1'b0;
    cyc();
    n_tests += 3;
    if (bus.halted !== 1'b1) begin n_fail++; $display("FAIL hbr_oor_halted: got %b, expected 1", bus.halted); end
    if (bus.mem_addr !== 32'h100) begin n_fail++; $display("FAIL hbr_oor_pc: got %h, expected 00000100", bus.mem_addr); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL hbr_oor_valid: got %b, expected 0", bus.out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    push_run(32'h0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    for (int i = 0; i < 4; i++) begin
      n_tests += 2;
      if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 32'h0, 32'h0050_0093}) begin
        n_fail++;
        $display("FAIL bp_hold%0d: valid=%b pc=%h instr=%h, expected 1/0/00500093", i, bus.out_valid, bus.out_pc, bus.out_instr);
      end
      if (bus.mem_addr !== 32'h4) begin n_fail++; $display("FAIL bp_addr%0d: got %h, expected 4", i, bus.mem_addr); end
      cyc();
    end
    bus.out_ready = 1'b1;
    run_to_halt("bp", 3);
  endtask

  task automatic test_branch();
    do_reset();
    sb_q.push_back('{pc: 32'h0, instr: rom_word(32'h0)});
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();                      // pc 0 valid, accepted at next edge
    cyc();                      // pc 4 valid
    bus.out_ready     = 1'b0;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h9;
    sb_q.push_back('{pc: 32'h8, instr: rom_word(32'h8)});
    cyc();
    bus.branch_taken = 1'b0;
    bus.out_ready    = 1'b1;
    n_tests += 2;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL br_flush: valid=%b, expected 0", bus.out_valid); end
    if (bus.mem_addr !== 32'h8) begin n_fail++; $display("FAIL br_target: got %h, expected 8", bus.mem_addr); end
    cyc();
    n_tests++;
    if ({bus.out_valid, bus.out_pc} !== {1'b1, 32'h8}) begin
      n_fail++;
      $display("FAIL br_next: valid=%b pc=%h, expected valid=1 pc=8", bus.out_valid, bus.out_pc);
    end
    run_to_halt("br", 2);
  endtask

  task automatic test_corners();
    do_reset();
    bus.out_ready     = 1'b1;
    bus.branch_taken  = 1'b1;
    bus.branch_target = 32'h8;
    cyc();
    bus.branch_taken = 1'b0;
    cyc();
    n_tests += 2;
    if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL idle_branch_pc: got %h, expected 0", bus.mem_addr); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL idle_branch_valid: got %b, expected 0", bus.out_valid); end

    push_run(32'h0);
    bus.start = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    bus.start = 1'b1;           // ignored while fetching
    cyc();
    bus.start = 1'b0;
    run_to_halt("fetch_start", 3);

    do_reset();
    push_run(32'h0);
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    cyc();
    bus.start = 1'b0;
    cyc();
    cyc();
    reset = 1'b1;
    cyc();
    n_tests += 6;
    if (bus.mem_addr !== 32'h0) begin n_fail++; $display("FAIL midrst_addr: got %h, expected 0", bus.mem_addr); end
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valid: got %b, expected 0", bus.out_valid); end
    if (bus.out_instr !== 32'h0) begin n_fail++; $display("FAIL midrst_instr: got %h, expected 0", bus.out_instr); end
    if (bus.out_pc !== 32'h0) begin n_fail++; $display("FAIL midrst_pc: got %h, expected 0", bus.out_pc); end
    if (bus.halted !== 1'b0) begin n_fail++; $display("FAIL midrst_halted: got %b, expected 0", bus.halted); end
    if (bus.fetch_count !== 16'h0) begin n_fail++; $display("FAIL midrst_count: got %0d, expected 0", bus.fetch_count); end
    reset = 1'b0;
    sb_q.delete();
    cyc();
    cyc();
    n_tests++;
    if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_idle: valid=%b after reset, expected 0", bus.out_valid); end
  endtask

  initial begin
    reset             = 1'b1;
    bus.start         = 1'b0;
    bus.branch_taken  = 1'b0;
    bus.branch_target = 32'h0;
    bus.out_ready     = 1'b0;
    test_reset();
    test_basic();
    test_halt_branch();
    test_backpressure();
    test_branch();
    test_corners();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_controller.md
# fetch_controller

Sequences the combinational instruction ROM for the single-cycle datapath: owns the program counter, drives the ROM byte address, and presents each fetched instruction with its PC to the decode stage over a valid/ready handshake. It also handles start-up, branch redirects with flush, end-of-program halt and a delivered-instruction count. It sits between the ROM and decode; the ROM stays a separate instance.

## Interface
- NUM_INSTRUCTIONS, 3: words in the ROM; valid byte addresses are 0 .. 4*NUM_INSTRUCTIONS-4.
- RESET_PC, 0: PC loaded on reset; word aligned.
- COUNT_W, 16: width of fetch_count.

- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; leaves IDLE.
- mem_addr  out  32  byte address to ROM; always equals pc.
- mem_instr  in  32  ROM word for mem_addr, same cycle (combinational).
- branch_taken  in  1  redirect request, sampled every cycle.
- branch_target  in  32  redirect byte address.
- out_valid  out  1  out_instr/out_pc hold a fetched instruction.
- out_ready  in  1  decode accepts when out_valid && out_ready.
- out_instr  out  32  fetched instruction.
- out_pc  out  32  byte address of out_instr.
- halted  out  1  in HALT with output register empty.
- fetch_count  out  COUNT_W  handshakes completed since reset; saturates at all-ones.

## Operation
- States: IDLE, FETCH, HALT. Output register is a single-entry buffer (out_valid, out_instr, out_pc).
- IDLE: no fetch. start -> FETCH. branch_taken ignored.
- FETCH, per cycle, in priority order:
  - branch_taken: pc <= {branch_target[31:2], 2'b00}; out_valid <= 0 (flush). If the aligned target is out of range -> HALT, else stay in FETCH.
  - pc out of range (pc >= 4*NUM_INSTRUCTIONS): -> HALT; no load.
  - Output slot free (!out_valid or out_ready): out_instr <= mem_instr, out_pc <= pc, out_valid <= 1, pc <= pc+4.
  - Otherwise stall: pc and output register held.
- HALT: no loads. out_valid drains normally via handshake. branch_taken to an in-range target -> FETCH with pc = aligned target; out-of-range target stays in HALT with pc updated. start ignored.
- halted = (state == HALT) && !out_valid.
- fetch_count increments on every out_valid && out_ready cycle in any state, including the cycle a branch flushes the slot; it holds at 2^COUNT_W-1.
- pc arithmetic is 32-bit modulo. pc+4 past the last word is out of range and leads to HALT on the next cycle.

## Timing
- Reset values: state IDLE, pc = RESET_PC, mem_addr = RESET_PC, out_valid 0, out_instr 0, out_pc 0, halted 0, fetch_count 0.
- Reset asserted mid-operation overrides everything in that cycle; the in-flight instruction is discarded and not counted.
- start at edge N: FETCH from N+1. First out_valid is visible after edge N+2; latency from start is 2 cycles.
- With out_ready held high, throughput is one instruction per cycle and there are no bubbles.
- Branch at edge N: the target instruction appears on out_valid after edge N+2. Exactly one slot is lost to the flush.
- The last instruction at byte address 4*NUM_INSTRUCTIONS-4 is loaded. One cycle later the FETCH state sees pc out of range and moves to HALT. halted rises the cycle after the final handshake.
- out_instr and out_pc are stable while out_valid && !out_ready.

## Structure
- Shared package fetch_pkg holds:
  - the state enum (IDLE, FETCH, HALT)
  - INSTR_W = 32
  - BYTES_PER_WORD = 4
  - the PC alignment mask
- One sub-module is natural: fetch_out_reg, the single-entry valid/ready output buffer with load, flush and hold inputs. Next-state logic, pc and the counter stay in fetch_controller.

## Test plan
- Basic run: NUM_INSTRUCTIONS=3, ROM {0x00500093, 0x00A00113, 0x002081B3}, out_ready=1, start pulse -> three handshakes with out_pc 0, 4, 8 on consecutive cycles; halted=1 after the third; fetch_count=3.
- Backpressure: out_ready=0 for 4 cycles after the first valid -> out_instr=0x00500093 and out_pc=0 stay stable; mem_addr holds at 4; after release, pc 4 and 8 follow with no loss or duplication.
- Branch: branch_taken with target 0x9 while out_pc=4 is valid and unaccepted -> flushed entry is not counted; the next valid has out_pc=8; the flush costs exactly 1 cycle.
- Branch from HALT: after halt, branch_taken with target 0 -> out_pc 0, 4, 8 are delivered again and fetch_count=6. A target of 0x100 instead keeps halted=1.
- Corner cases: start while in FETCH and branch_taken in IDLE -> no effect. Reset asserted mid-stream -> all outputs return to reset values at the next edge.
